i2c_capture_ctrl: RTL and testbench

Controller that sequences the I2C analyzer's capture RAM from a single system clock instead of clocking logic directly off SCL/SDA. It synchronises both bus lines, detects START/STOP and bit edges, and assembles each 9-bit transfer (byte + ACK) into a tagged word. It issues exactly one RAM write per completed byte, stops when the RAM is full, and owns the read pointer that the front panel steps through for the 7-segment display.

---
 rtl/i2c_capture_ctrl_pkg.sv | 18 +
 rtl/i2c_capture_ctrl_if.sv | 33 +++
 rtl/i2c_capture_ctrl_bus_sync.sv | 47 ++++
 rtl/i2c_capture_ctrl.sv | 162 ++++++++++++++++
 tb/tb_i2c_capture_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_capture_ctrl_pkg.sv
// Shared types and capture-word layout for the I2C analyzer capture controller.
// A capture word is {start_flag, ack, byte[7:0]}.
package i2ca_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        WRITE,
        DONE
    } cap_state_t;

    localparam int WD_BYTE_LSB  = 0;
    localparam int WD_ACK_BIT   = 8;
    localparam int WD_SFLAG_BIT = 9;
    localparam int WD_W         = 10;

endpackage

// File: rtl/i2c_capture_ctrl_if.sv
// Front-panel / bus / capture-RAM signal bundle of the capture controller.
import i2ca_pkg::*;

interface i2c_capture_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              scl;
    logic              sda;
    logic              arm;
    logic              clr;
    logic              rd_up;
    logic              rd_dn;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_wraddr;
    logic [WD_W-1:0]   mem_wdata;
    logic [ADDR_W-1:0] mem_rdaddr;
    logic [ADDR_W:0]   cap_count;
    logic              bus_busy;
    logic              full;
    logic              capturing;

    modport slave (
        input  scl, sda, arm, clr, rd_up, rd_dn,
        output mem_wren, mem_wraddr, mem_wdata, mem_rdaddr,
        output cap_count, bus_busy, full, capturing
    );

    modport master (
        output scl, sda, arm, clr, rd_up, rd_dn,
        input  mem_wren, mem_wraddr, mem_wdata, mem_rdaddr,
        input  cap_count, bus_busy, full, capturing
    );
endinterface

// File: rtl/i2c_capture_ctrl_bus_sync.sv
// Brings raw SCL/SDA into the clk domain and decodes bit-clock, START and STOP
// events from the synchronised lines only.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic start_ev,
    output logic stop_ev,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_q;
    logic                   sda_q;

    // Sync chains reset to the idle-bus level so release never fakes an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes the chain a chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SDA transitions only count as START/STOP while SCL is steadily high,
    // so an SCL edge coincident with an SDA change is an SCL edge only.
    assign scl_rise = scl_s & ~scl_q;
    assign start_ev = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_ev  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_capture_ctrl.sv
// I2C analyzer capture sequencer: assembles byte+ACK transfers into tagged words,
// writes one RAM word per byte until full, and owns the display read pointer.
import i2ca_pkg::*;

module i2c_capture_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    i2c_capture_ctrl_if.slave  bus
);
    logic scl_rise;
    logic start_ev;
    logic stop_ev;
    logic sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (bus.scl),
        .sda      (bus.sda),
        .scl_rise (scl_rise),
        .start_ev (start_ev),
        .stop_ev  (stop_ev),
        .sda_s    (sda_s)
    );

    cap_state_t        state,      state_n;
    logic [3:0]        bit_cnt,    bit_cnt_n;
    logic [7:0]        shreg,      shreg_n;
    logic              ack_r,      ack_n;
    logic              start_flag, start_flag_n;
    logic [ADDR_W:0]   cap_count,  cap_count_n;
    logic [ADDR_W:0]   cap_inc;
    logic [ADDR_W-1:0] rd_ptr;
    logic              bus_busy;
    logic [WD_W-1:0]   wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ack_r      <= 1'b0;
            start_flag <= 1'b0;
            cap_count  <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            ack_r      <= ack_n;
            start_flag <= start_flag_n;
            cap_count  <= cap_count_n;
        end
    end

    assign cap_inc = cap_count + 1'b1;

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        ack_n        = ack_r;
        start_flag_n = start_flag;
        cap_count_n  = cap_count;

        unique case (state)
            IDLE: begin
                if (bus.arm) state_n = WAIT_START;
            end
            WAIT_START: begin
                if (start_ev) begin
                    state_n      = SHIFT;
                    bit_cnt_n    = '0;
                    start_flag_n = 1'b1;
                end
            end
            SHIFT: begin
                if (start_ev) begin
                    // Repeated START: drop the partial byte and re-tag.
                    bit_cnt_n    = '0;
                    start_flag_n = 1'b1;
                end else if (stop_ev) begin
                    bit_cnt_n = '0;
                    state_n   = WAIT_START;
                end else if (scl_rise) begin
                    if (bit_cnt == 4'd8) begin
                        ack_n   = sda_s;
                        state_n = WRITE;
                    end else begin
                        shreg_n   = {shreg[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            WRITE: begin
                cap_count_n  = cap_inc;
                start_flag_n = 1'b0;
                bit_cnt_n    = '0;
                state_n      = cap_inc[ADDR_W] ? DONE : SHIFT;
            end
            DONE: begin
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase

        // Clear overrides everything, including a same-cycle arm; a WRITE in
        // progress still drives its word this cycle since wren is decoded from state.
        if (bus.clr) begin
            state_n      = IDLE;
            cap_count_n  = '0;
            start_flag_n = 1'b0;
            bit_cnt_n    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_busy <= 1'b0;
        end else if (start_ev) begin
            bus_busy <= 1'b1;
        end else if (stop_ev) begin
            bus_busy <= 1'b0;
        end
    end

    // Read pointer wraps both ways; simultaneous up/down cancels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (bus.clr) begin
            rd_ptr <= '0;
        end else if (bus.rd_up && !bus.rd_dn) begin
            rd_ptr <= rd_ptr + 1'b1;
        end else if (bus.rd_dn && !bus.rd_up) begin
            rd_ptr <= rd_ptr - 1'b1;
        end
    end

    always_comb begin
        wdata                          = '0;
        wdata[WD_SFLAG_BIT]            = start_flag;
        wdata[WD_ACK_BIT]              = ack_r;
        wdata[WD_BYTE_LSB +: 8]        = shreg;
    end

    assign bus.mem_wren   = (state == WRITE);
    assign bus.mem_wraddr = cap_count[ADDR_W-1:0];
    assign bus.mem_wdata  = wdata;
    assign bus.mem_rdaddr = rd_ptr;
    assign bus.cap_count  = cap_count;
    assign bus.bus_busy   = bus_busy;
    assign bus.full       = cap_count[ADDR_W];
    assign bus.capturing  = (state == WAIT_START) || (state == SHIFT) || (state == WRITE);

endmodule

// File: tb/tb_i2c_capture_ctrl.sv
// Directed bench for i2c_capture_ctrl: a default-depth instance and a 4-word
// instance share the bus stimulus; each has its own arm and write log.
module tb_i2c_capture_ctrl;

    localparam time T_CLK_HALF = 10ns;
    localparam time T_Q        = 200ns;

    logic clk;
    logic rst;
    logic scl;
    logic sda;
    logic arm8;
    logic arm2;
    logic clr;
    logic rd_up;
    logic rd_dn;

    int n_tests;
    int n_fail;

    logic [17:0] q8[$];
    logic [11:0] q2[$];

    i2c_capture_ctrl_if #(.ADDR_W(8)) if8 ();
    i2c_capture_ctrl_if #(.ADDR_W(2)) if2 ();

    assign if8.scl   = scl;
    assign if8.sda   = sda;
    assign if8.arm   = arm8;
    assign if8.clr   = clr;
    assign if8.rd_up = rd_up;
    assign if8.rd_dn = rd_dn;
    assign if2.scl   = scl;
    assign if2.sda   = sda;
    assign if2.arm   = arm2;
    assign if2.clr   = clr;
    assign if2.rd_up = rd_up;
    assign if2.rd_dn = rd_dn;

    i2c_capture_ctrl #(.ADDR_W(8), .SYNC_STAGES(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    i2c_capture_ctrl #(.ADDR_W(2), .SYNC_STAGES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial begin
        clk = 1'b0;
        forever #T_CLK_HALF clk = ~clk;
    end

    always @(negedge clk) begin
        if (if8.mem_wren) q8.push_back({if8.mem_wraddr, if8.mem_wdata});
        if (if2.mem_wren) q2.push_back({if2.mem_wraddr, if2.mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_arm8();
        @(negedge clk) arm8 = 1'b1;
        @(negedge clk) arm8 = 1'b0;
    endtask

    task automatic pulse_arm2();
        @(negedge clk) arm2 = 1'b1;
        @(negedge clk) arm2 = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic pulse_rd(input logic up, input logic dn);
        @(negedge clk) begin rd_up = up; rd_dn = dn; end
        @(negedge clk) begin rd_up = 1'b0; rd_dn = 1'b0; end
        @(negedge clk);
    endtask

    task automatic i2c_start();
        scl = 1'b1; sda = 1'b1; #T_Q;
        sda = 1'b0;             #T_Q;
        scl = 1'b0;             #T_Q;
    endtask

    task automatic i2c_rstart();
        sda = 1'b1; #T_Q;
        scl = 1'b1; #T_Q;
        sda = 1'b0; #T_Q;
        scl = 1'b0; #T_Q;
    endtask

    task automatic i2c_stop();
        sda = 1'b0; #T_Q;
        scl = 1'b1; #T_Q;
        sda = 1'b1; #T_Q;
    endtask

    task automatic send_bit(input logic b);
        sda = b;    #T_Q;
        scl = 1'b1; #T_Q;
        scl = 1'b0; #T_Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(ack);
    endtask

    function automatic logic [17:0] q8_at(input int i);
        return (q8.size() > i) ? q8[i] : 18'h3ffff;
    endfunction

    function automatic logic [11:0] q2_at(input int i);
        return (q2.size() > i) ? q2[i] : 12'hfff;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; scl = 1'b1; sda = 1'b1;
        arm8 = 1'b0; arm2 = 1'b0; clr = 1'b0; rd_up = 1'b0; rd_dn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_wren",      32'(if8.mem_wren),   32'd0);
        check("rst_cap_count", 32'(if8.cap_count),  32'd0);
        check("rst_bus_busy",  32'(if8.bus_busy),   32'd0);
        check("rst_capturing", 32'(if8.capturing),  32'd0);
        check("rst_full",      32'(if8.full),       32'd0);
        check("rst_rdaddr",    32'(if8.mem_rdaddr), 32'd0);
        check("rst_wdata",     32'(if8.mem_wdata),  32'd0);

        // 1: single byte 0xA5 with ACK
        pulse_arm8();
        check("t1_capturing", 32'(if8.capturing), 32'd1);
        i2c_start();
        send_byte(8'hA5, 1'b0);
        check("t1_busy_mid", 32'(if8.bus_busy), 32'd1);
        i2c_stop();
        check("t1_nwrites",   32'(q8.size()),    32'd1);
        check("t1_word0",     32'(q8_at(0)),     32'({8'd0, 10'h2A5}));
        check("t1_cap_count", 32'(if8.cap_count), 32'd1);
        check("t1_busy_end",  32'(if8.bus_busy),  32'd0);
        check("t1_capturing_after", 32'(if8.capturing), 32'd1);
        check("t1_dut2_idle", 32'(q2.size()),     32'd0);

        // 2: NACKed byte, repeated START, ACKed byte
        pulse_clr();
        q8.delete();
        pulse_arm8();
        i2c_start();
        send_byte(8'h3C, 1'b1);
        i2c_rstart();
        send_byte(8'h81, 1'b0);
        i2c_stop();
        check("t2_nwrites",   32'(q8.size()),     32'd2);
        check("t2_word0",     32'(q8_at(0)),      32'({8'd0, 10'h33C}));
        check("t2_word1",     32'(q8_at(1)),      32'({8'd1, 10'h281}));
        check("t2_cap_count", 32'(if8.cap_count), 32'd2);

        // 3: STOP after 4 bits, then a clean byte
        pulse_clr();
        q8.delete();
        pulse_arm8();
        i2c_start();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        i2c_stop();
        check("t3_no_partial", 32'(q8.size()), 32'd0);
        i2c_start();
        send_byte(8'h55, 1'b0);
        i2c_stop();
        check("t3_nwrites",   32'(q8.size()),     32'd1);
        check("t3_word0",     32'(q8_at(0)),      32'({8'd0, 10'h255}));
        check("t3_cap_count", 32'(if8.cap_count), 32'd1);

        // 4: 4-word buffer fills after four bytes, fifth is dropped
        pulse_clr();
        q8.delete();
        q2.delete();
        pulse_arm2();
        i2c_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("t4_full_at4", 32'(if2.full), 32'd1);
        send_byte(8'h55, 1'b0);
        i2c_stop();
        check("t4_nwrites",   32'(q2.size()),     32'd4);
        check("t4_word0",     32'(q2_at(0)),      32'({2'd0, 10'h211}));
        check("t4_word1",     32'(q2_at(1)),      32'({2'd1, 10'h022}));
        check("t4_word2",     32'(q2_at(2)),      32'({2'd2, 10'h033}));
        check("t4_word3",     32'(q2_at(3)),      32'({2'd3, 10'h044}));
        check("t4_full",      32'(if2.full),      32'd1);
        check("t4_cap_count", 32'(if2.cap_count), 32'd4);
        check("t4_done_not_capturing", 32'(if2.capturing), 32'd0);
        check("t4_dut8_unarmed", 32'(q8.size()), 32'd0);
        pulse_clr();
        check("t4_clr_full",      32'(if2.full),      32'd0);
        check("t4_clr_cap_count", 32'(if2.cap_count), 32'd0);

        // 5: read pointer wraps and cancels
        check("t5_rd_start", 32'(if8.mem_rdaddr), 32'd0);
        pulse_rd(1'b0, 1'b1);
        check("t5_rd_dn_wrap", 32'(if8.mem_rdaddr), 32'd255);
        check("t5_rd_dn_wrap2", 32'(if2.mem_rdaddr), 32'd3);
        pulse_rd(1'b1, 1'b0);
        pulse_rd(1'b1, 1'b0);
        check("t5_rd_up2", 32'(if8.mem_rdaddr), 32'd1);
        pulse_rd(1'b1, 1'b1);
        check("t5_rd_both", 32'(if8.mem_rdaddr), 32'd1);
        check("t5_rd_both2", 32'(if2.mem_rdaddr), 32'd1);

        // 6: reset mid-byte
        q8.delete();
        pulse_arm8();
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t6_pre_busy",      32'(if8.bus_busy),  32'd1);
        check("t6_pre_capturing", 32'(if8.capturing), 32'd1);
        @(negedge clk);
        #3ns rst = 1'b1;
        #1ns;
        check("t6_rst_busy",      32'(if8.bus_busy),   32'd0);
        check("t6_rst_capturing", 32'(if8.capturing),  32'd0);
        check("t6_rst_rdaddr",    32'(if8.mem_rdaddr), 32'd0);
        check("t6_rst_wren",      32'(if8.mem_wren),   32'd0);
        check("t6_rst_cap_count", 32'(if8.cap_count),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_byte(8'h99, 1'b0);
        i2c_stop();
        check("t6_no_write_unarmed", 32'(q8.size()), 32'd0);
        pulse_arm8();
        i2c_start();
        send_byte(8'hC3, 1'b0);
        i2c_stop();
        check("t6_nwrites", 32'(q8.size()), 32'd1);
        check("t6_word0",   32'(q8_at(0)),  32'({8'd0, 10'h2C3}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
